seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first, repeat_cnt+1 times,
// with GAP_CYCLES idle cycles between sends. Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit per send.
module seq_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int RPT_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_cnt,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | a pattern (or parity) bit is on d_out
  // GAP   | idle gap between repetitions, busy held high
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [WIDTH-1:0] pat_copy, pat_n;
  logic [RPT_W-1:0] rpt_left, rpt_n;
  logic [IW-1:0]    bit_idx, idx_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             d_out_n, d_valid_n, busy_n, done_n;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic             par_phase, par_n;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      pat_copy  <= '0;
      rpt_left  <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      d_out     <= 1'b0;
      d_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_phase <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      pat_copy  <= pat_n;
      rpt_left  <= rpt_n;
      bit_idx   <= idx_n;
      gap_cnt   <= gap_n;
      d_out     <= d_out_n;
      d_valid   <= d_valid_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_phase <= par_n;
`endif
    end
  end

  // Outputs are computed one cycle ahead so the registered values describe the coming cycle.
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    pat_n     = pat_copy;
    rpt_n     = rpt_left;
    idx_n     = bit_idx;
    gap_n     = gap_cnt;
    d_out_n   = 1'b0;
    d_valid_n = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_n     = par_phase;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          pat_n     = pattern;
          shift_n   = pattern;
          rpt_n     = repeat_cnt;
          idx_n     = IDX_TOP;
          d_out_n   = pattern[WIDTH-1];
          d_valid_n = 1'b1;
          busy_n    = 1'b1;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        busy_n = 1'b1;
        if (bit_idx != '0) begin
          shift_n   = {shift_reg[WIDTH-2:0], 1'b0};
          idx_n     = bit_idx - 1'b1;
          d_out_n   = shift_reg[WIDTH-2];
          d_valid_n = 1'b1;
        end
`ifdef SEQ_PATTERN_TX_PARITY_EN
        else if (!par_phase) begin
          par_n     = 1'b1;
          d_out_n   = ^pat_copy;
          d_valid_n = 1'b1;
        end
`endif
        else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_n = 1'b0;
`endif
          if (rpt_left != '0) begin
            rpt_n = rpt_left - 1'b1;
            if (GAP_CYCLES > 0) begin
              gap_n   = GAP_LOAD;
              state_n = GAP;
            end else begin
              shift_n   = pat_copy;
              idx_n     = IDX_TOP;
              d_out_n   = pat_copy[WIDTH-1];
              d_valid_n = 1'b1;
            end
          end else begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt != '0) begin
          gap_n = gap_cnt - 1'b1;
        end else begin
          shift_n   = pat_copy;
          idx_n     = IDX_TOP;
          d_out_n   = pat_copy[WIDTH-1];
          d_valid_n = 1'b1;
          state_n   = SHIFT;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a vector table for single frames and start handling,
// plus hand-written repeat, back-to-back, max-repeat, mid-frame reset and parity sequences.
module tb_seq_pattern_tx;
  localparam int WIDTH = 8;
  localparam int RPT_W = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             start, start0;
  logic [WIDTH-1:0] pattern, pattern0;
  logic [RPT_W-1:0] repeat_cnt, repeat_cnt0;
  logic             d_out, d_valid, busy, done;
  logic             d_out0, d_valid0, busy0, done0;

  always #5 clock = ~clock;

  seq_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(2), .RPT_W(RPT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern), .repeat_cnt(repeat_cnt),
    .d_out(d_out), .d_valid(d_valid), .busy(busy), .done(done));

  seq_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(0), .RPT_W(RPT_W)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .pattern(pattern0), .repeat_cnt(repeat_cnt0),
    .d_out(d_out0), .d_valid(d_valid0), .busy(busy0), .done(done0));

  int checks = 0;
  int errors = 0;

  // exp = {d_out, d_valid, busy, done} seen in the cycle after the edge that samples the inputs
  typedef struct packed {
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [RPT_W-1:0] rpt;
    logic [3:0]       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic s, logic [WIDTH-1:0] p, logic [RPT_W-1:0] r, logic [3:0] e);
    vec_t v;
    v.start = s; v.pattern = p; v.rpt = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [3:0] get_out(bit sel);
    return sel ? {d_out0, d_valid0, busy0, done0} : {d_out, d_valid, busy, done};
  endfunction

  // Expected outputs n cycles after the accepting edge (n starts at 1).
  function automatic logic [3:0] model(logic [WIDTH-1:0] pat, int rpt, int gap, int n);
    int flen  = WIDTH + PAR;
    int per   = flen + gap;
    int total = (rpt + 1) * flen + rpt * gap;
    int pos;
    if (n <= total) begin
      pos = (n - 1) % per;
      if (pos < WIDTH) return {pat[WIDTH-1-pos], 3'b110};
      if (pos < flen)  return {^pat, 3'b110};
      return 4'b0010;
    end
    if (n == total + 1) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic check(string name, int cyc, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: {d_out,d_valid,busy,done} got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit sel, logic s, logic [WIDTH-1:0] p, logic [RPT_W-1:0] r);
    if (sel) begin
      start0 = s; pattern0 = p; repeat_cnt0 = r;
    end else begin
      start = s; pattern = p; repeat_cnt = r;
    end
  endtask

  task automatic run_frame(string name, bit sel, logic [WIDTH-1:0] pat, int rpt, int gap);
    int total = (rpt + 1) * (WIDTH + PAR) + rpt * gap;
    drive(sel, 1'b1, pat, RPT_W'(rpt));
    for (int n = 1; n <= total + 2; n++) begin
      tick();
      if (n == 1) drive(sel, 1'b0, ~pat, '0);
      check(name, n, get_out(sel), model(pat, rpt, gap, n));
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    repeat (3) tick();
    check("reset_state", 0, get_out(1'b0), 4'b0000);
    check("reset_state0", 0, get_out(1'b1), 4'b0000);
    reset = 1'b0;
    tick();

    // A5 frame with start retriggered mid-SHIFT and during DONE, then 81 started right after DONE.
    add(1'b1, 8'hA5, 4'd0, 4'b1110);
    add(1'b0, 8'hA5, 4'd0, 4'b0110);
    add(1'b1, 8'h00, 4'd3, 4'b1110);
    add(1'b0, 8'h00, 4'd3, 4'b0110);
    add(1'b0, 8'h00, 4'd3, 4'b0110);
    add(1'b0, 8'h00, 4'd3, 4'b1110);
    add(1'b0, 8'h00, 4'd3, 4'b0110);
    add(1'b0, 8'h00, 4'd3, 4'b1110);
`ifdef SEQ_PATTERN_TX_PARITY_EN
    add(1'b0, 8'h00, 4'd3, 4'b0110);
`endif
    add(1'b0, 8'h00, 4'd0, 4'b0001);
    add(1'b1, 8'hFF, 4'd2, 4'b0000);
    add(1'b1, 8'h81, 4'd0, 4'b1110);
    for (int k = 0; k < 6; k++) add(1'b0, 8'h00, 4'd0, 4'b0110);
    add(1'b0, 8'h00, 4'd0, 4'b1110);
`ifdef SEQ_PATTERN_TX_PARITY_EN
    add(1'b0, 8'h00, 4'd0, 4'b0110);
`endif
    add(1'b0, 8'h00, 4'd0, 4'b0001);
    add(1'b0, 8'h00, 4'd0, 4'b0000);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].start, vecs[i].pattern, vecs[i].rpt);
      tick();
      check($sformatf("vec%0d", i), i, get_out(1'b0), vecs[i].exp);
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();

    run_frame("rpt2_gap2", 1'b0, 8'b1010_0000, 2, 2);
    run_frame("ff_nogap", 1'b1, 8'hFF, 1, 0);
    run_frame("rpt_max_nogap", 1'b1, 8'hC3, 15, 0);
    run_frame("rpt_max_gap", 1'b0, 8'h5A, 15, 2);

    // Reset while bit 4 of an A5 frame is on the line.
    drive(1'b0, 1'b1, 8'hA5, 4'd1);
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 1) drive(1'b0, 1'b0, 8'h00, 4'd0);
      check("pre_reset", n, get_out(1'b0), model(8'hA5, 1, 2, n));
    end
    reset = 1'b1;
    tick();
    check("mid_reset", 0, get_out(1'b0), 4'b0000);
    reset = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      check("post_reset_idle", n, get_out(1'b0), 4'b0000);
    end
    run_frame("after_reset", 1'b0, 8'h3C, 0, 2);

    run_frame("parity_07", 1'b0, 8'h07, 0, 2);
    run_frame("parity_03", 1'b1, 8'h03, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
